xbar_read_return_arbiter: RTL

Per-master read-data return arbiter for the crossbar. It selects one slave-side R FIFO whose front beat is addressed to this master and holds that grant until the RLAST beat has transferred. It drives the grant number and push qualifier that the slave interfaces use to pop their R FIFOs into this master's return FIFO. One instance sits on each master port; the write-response path reuses it with single-beat bursts (last tied high).

---
 rtl/xbar_read_return_arbiter_if.sv | 46 ++++
 rtl/xbar_read_return_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/xbar_read_return_arbiter_if.sv
// xbar_read_return_arbiter_if
// Bundles the signals between one master's read-return arbiter and the
// crossbar's slave-side R FIFOs and master-side return FIFO.
//   slave_read_data_fifo_empty   : per-slave R FIFO empty
//   read_data_return_dest_master : decoded destination master of each front beat
//   slave_read_data_last         : RLAST of each slave's front beat
//   master_read_data_fifo_full   : this master's return FIFO is full
//   grant_slave_number           : granted slave index, value `slaves` = no grant
//   push_to_fifo                 : granted slave's front beat is valid for this master
//   burst_locked                 : arbiter is holding a burst grant
// Modport slave is used by the arbiter; modport master by the surrounding fabric.
interface xbar_read_return_arbiter_if #(
  parameter int masters = 2,
  parameter int slaves  = 2
) ();
  localparam int MW = $clog2(masters);
  localparam int GW = $clog2(slaves) + 1;

  logic [0:slaves-1] slave_read_data_fifo_empty;
  logic [MW-1:0]     read_data_return_dest_master [0:slaves-1];
  logic [0:slaves-1] slave_read_data_last;
  logic              master_read_data_fifo_full;
  logic [GW-1:0]     grant_slave_number;
  logic              push_to_fifo;
  logic              burst_locked;

  modport slave (
    input  slave_read_data_fifo_empty,
    input  read_data_return_dest_master,
    input  slave_read_data_last,
    input  master_read_data_fifo_full,
    output grant_slave_number,
    output push_to_fifo,
    output burst_locked
  );

  modport master (
    output slave_read_data_fifo_empty,
    output read_data_return_dest_master,
    output slave_read_data_last,
    output master_read_data_fifo_full,
    input  grant_slave_number,
    input  push_to_fifo,
    input  burst_locked
  );
endinterface

// File: rtl/xbar_read_return_arbiter.sv
// xbar_read_return_arbiter
// Per-master read-data return arbiter. Picks, round-robin, one slave R FIFO
// whose front beat targets this master and holds that grant until the RLAST
// beat has transferred into this master's return FIFO.
// Ports:
//   ACLK    : clock, rising edge
//   ARESETn : synchronous active-low reset
//   bus     : xbar_read_return_arbiter_if.slave (see interface header)
module xbar_read_return_arbiter #(
  parameter int masters            = 2,
  parameter int slaves             = 2,
  parameter int i_am_master_number = 0
) (
  input logic                       ACLK,
  input logic                       ARESETn,
  xbar_read_return_arbiter_if.slave bus
);
  localparam int SW = $clog2(slaves);
  localparam int GW = SW + 1;
  localparam int MW = $clog2(masters);

  localparam logic [GW-1:0] NO_GRANT = GW'(slaves);
  localparam logic [SW-1:0] RR_RESET = SW'(slaves - 1);
  localparam logic [MW-1:0] MY_ID    = MW'(i_am_master_number);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t            state;
  logic [SW-1:0]     rr_last;
  logic [GW-1:0]     grant;
  logic              locked;

  logic [slaves-1:0] req;
  logic              any_req;
  logic [SW-1:0]     winner;
  logic              found;
  logic              take;
  int                scan_idx;
  logic [SW-1:0]     g_idx;
  logic              push;
  logic              xfer_last;

  // Per-slave request: front beat present and addressed to this master.
  always_comb begin
    req = '0;
    for (int s = 0; s < slaves; s++) begin
      req[s] = ~bus.slave_read_data_fifo_empty[s] &
               (bus.read_data_return_dest_master[s] == MY_ID);
    end
  end

  // Round-robin pick starting just after the last released slave. The wrap is
  // an explicit subtract so non-power-of-two slave counts scan correctly.
  always_comb begin
    any_req  = |req;
    winner   = '0;
    found    = 1'b0;
    take     = 1'b0;
    scan_idx = 0;
    for (int i = 1; i <= slaves; i++) begin
      scan_idx = int'(rr_last) + i;
      scan_idx = (scan_idx >= slaves) ? (scan_idx - slaves) : scan_idx;
      take     = ~found & req[scan_idx];
      winner   = take ? SW'(scan_idx) : winner;
      found    = found | take;
    end
  end

  // push_to_fifo is combinational from the held grant so a beat can move on
  // the first LOCK cycle; it is deliberately not gated by full.
  always_comb begin
    g_idx     = grant[SW-1:0];
    push      = (state == LOCK) ? req[g_idx] : 1'b0;
    xfer_last = push & ~bus.master_read_data_fifo_full & bus.slave_read_data_last[g_idx];
  end

  assign bus.grant_slave_number = grant;
  assign bus.push_to_fifo       = push;
  assign bus.burst_locked       = locked;

  // Grant FSM: IDLE arbitrates, LOCK holds until the RLAST beat transfers.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state   <= IDLE;
      grant   <= NO_GRANT;
      locked  <= 1'b0;
      rr_last <= RR_RESET;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant  <= {1'b0, winner};
            locked <= 1'b1;
            state  <= LOCK;
          end else begin
            grant  <= NO_GRANT;
            locked <= 1'b0;
          end
        end
        LOCK: begin
          // Starved or backpressured beats simply hold the lock.
          if (xfer_last) begin
            rr_last <= g_idx;
            grant   <= NO_GRANT;
            locked  <= 1'b0;
            state   <= IDLE;
          end else begin
            locked  <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          grant  <= NO_GRANT;
          locked <= 1'b0;
        end
      endcase
    end
  end
endmodule
